// File: rtl/lbus_cmd_master_pkg.sv
// ----------------------------------------------------------------------------
// lbus_pkg
// Shared definitions for the local-bus command master: the bus FSM state
// encoding and helpers that locate the fields inside a packed command word
// {rd, address, write data}.
// Ports: none (package).
// ----------------------------------------------------------------------------
package lbus_pkg;

   // Bus sequencer states, in the order a transaction walks through them
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ALE,
      ST_AWAIT,
      ST_ASSERT,
      ST_WAIT_ACK,
      ST_RELEASE
   } lbus_state_t;

   // The read flag sits directly above the address and data fields
   function automatic int rd_bit(input int aw, input int dw);
      return aw + dw;
   endfunction

   // The address field starts right above the write data
   function automatic int addr_lsb(input int dw);
      return dw;
   endfunction

   // Write data occupies the bottom of the command word
   function automatic int data_lsb();
      return 0;
   endfunction

   // Used to size the shared phase counter
   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage

// File: rtl/lbus_cmd_master_if.sv
// ----------------------------------------------------------------------------
// lbus_cmd_master_if
// Multiplexed local-bus signal bundle.
// Ports (signals):
//   ale    address latch enable          (master -> target)
//   cs_n   chip select, active low       (master -> target)
//   rd_wr  1 read / 0 write              (master -> target)
//   data   muxed address / write data    (master -> target)
//   ack_n  acknowledge, active low       (target -> master)
//   rdata  read data                     (target -> master)
// ----------------------------------------------------------------------------
interface lbus_cmd_master_if #(
   parameter int DW = 32
) ();

   logic          ale;
   logic          cs_n;
   logic          rd_wr;
   logic [DW-1:0] data;
   logic          ack_n;
   logic [DW-1:0] rdata;

   modport master (
      output ale, cs_n, rd_wr, data,
      input  ack_n, rdata
   );

   modport slave (
      input  ale, cs_n, rd_wr, data,
      output ack_n, rdata
   );

endinterface

// File: rtl/lbus_cmd_fifo.sv
// ----------------------------------------------------------------------------
// lbus_cmd_fifo
// Synchronous first-word-fall-through FIFO: dout always shows the oldest
// entry while empty is low, and pop simply advances past it.
// Ports:
//   clk, reset   clock / asynchronous active-high reset
//   push, din    write strobe and data (ignored while full)
//   pop          discard the head entry (ignored while empty)
//   dout         head entry
//   full, empty  occupancy flags
// DEPTH must be a power of two and at least 2.
// ----------------------------------------------------------------------------
module lbus_cmd_fifo #(
   parameter int WIDTH = 65,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [IDX_W-1:0] wr_idx;
   logic [IDX_W-1:0] rd_idx;
   logic [IDX_W:0]   count;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count == (IDX_W+1)'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign dout    = mem[rd_idx];

   // Storage needs no reset; only entries below count are ever observed
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_idx] <= din;
      end
   end

   // Index pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_idx <= '0;
         rd_idx <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_idx <= wr_idx + 1'b1;
         if (pop_ok)  rd_idx <= rd_idx + 1'b1;
         if (push_ok && !pop_ok) begin
            count <= count + 1'b1;
         end else if (pop_ok && !push_ok) begin
            count <= count - 1'b1;
         end
      end
   end

endmodule

// File: rtl/lbus_cmd_master.sv
// ----------------------------------------------------------------------------
// lbus_cmd_master
// Multi-channel local-bus command engine. Each of NCH producers pushes
// {rd, addr, wdata} commands into its own FIFO; a round-robin arbiter picks
// the next command and a bus FSM runs it as ale / wait / cs_n / ack cycles,
// returning a tagged response with read data or a timeout flag.
// Ports:
//   clk, reset        clock / asynchronous active-high reset
//   cmd, cmd_wr       per-channel command words and push strobes
//   cmd_full          per-channel FIFO full
//   cmd_ovf           sticky per-channel "pushed while full"
//   rsp_valid         one-cycle response pulse
//   rsp_ch, rsp_rd    originating channel, read flag
//   rsp_timeout       command aborted without acknowledge
//   rsp_data          read data (0 for writes and timeouts)
//   bus               multiplexed local bus, master side
//   busy              sequencer not idle
//   timeout_cnt       saturating timeout count
// ----------------------------------------------------------------------------
module lbus_cmd_master
   import lbus_pkg::*;
#(
   parameter int NCH        = 4,
   parameter int AW         = 32,
   parameter int DW         = 32,
   parameter int FIFO_DEPTH = 16,
   parameter int ALE_HOLD   = 1,
   parameter int ADDR_WAIT  = 2,
   parameter int TIMEOUT    = 256
) (
   input  logic                                     clk,
   input  logic                                     reset,
   input  logic [NCH*(1+AW+DW)-1:0]                 cmd,
   input  logic [NCH-1:0]                           cmd_wr,
   output logic [NCH-1:0]                           cmd_full,
   output logic [NCH-1:0]                           cmd_ovf,
   output logic                                     rsp_valid,
   output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] rsp_ch,
   output logic                                     rsp_rd,
   output logic                                     rsp_timeout,
   output logic [DW-1:0]                            rsp_data,
   lbus_cmd_master_if.master                        bus,
   output logic                                     busy,
   output logic [15:0]                              timeout_cnt
);

   localparam int CW       = 1 + AW + DW;
   localparam int CHW      = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int RD_POS   = rd_bit(AW, DW);
   localparam int ADDR_POS = addr_lsb(DW);
   localparam int DATA_POS = data_lsb();
   localparam int CNT_W    = $clog2(max3(ALE_HOLD, ADDR_WAIT, TIMEOUT) + 1);

   localparam logic [CNT_W-1:0] ALE_LAST   = CNT_W'(ALE_HOLD - 1);
   localparam logic [CNT_W-1:0] AWAIT_LAST = CNT_W'((ADDR_WAIT > 0) ? ADDR_WAIT - 1 : 0);
   localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT - 1);

   lbus_state_t      state;
   lbus_state_t      state_n;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_n;

   logic [CW-1:0]    fifo_dout [NCH];
   logic [NCH-1:0]   fifo_full;
   logic [NCH-1:0]   fifo_empty;
   logic [NCH-1:0]   pop;

   logic [CHW-1:0]   rr_ptr;
   logic [CHW:0]     cand_sum;
   logic [CHW-1:0]   cand_idx;
   logic             grant_valid;
   logic [CHW-1:0]   grant_ch;
   logic [CW-1:0]    grant_cmd;
   logic [DW-1:0]    addr_ext;

   logic             do_grant;
   logic             do_ack;
   logic             do_timeout;

   logic             cur_rd;
   logic [CHW-1:0]   cur_ch;
   logic [DW-1:0]    cur_wdata;

   // One FWFT FIFO per producer
   for (genvar g = 0; g < NCH; g++) begin : g_fifo
      lbus_cmd_fifo #(
         .WIDTH (CW),
         .DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .clk   (clk),
         .reset (reset),
         .push  (cmd_wr[g]),
         .din   (cmd[g*CW +: CW]),
         .pop   (pop[g]),
         .dout  (fifo_dout[g]),
         .full  (fifo_full[g]),
         .empty (fifo_empty[g])
      );
   end

   assign cmd_full = fifo_full;
   assign busy     = (state != ST_IDLE);

   // Round-robin search: first non-empty channel at or above rr_ptr,
   // wrapping; rr_ptr always holds last_grant+1
   always_comb begin
      grant_valid = 1'b0;
      grant_ch    = '0;
      cand_sum    = '0;
      cand_idx    = '0;
      for (int i = 0; i < NCH; i++) begin
         cand_sum = {1'b0, rr_ptr} + (CHW+1)'(i);
         if (cand_sum >= (CHW+1)'(NCH)) begin
            cand_sum = cand_sum - (CHW+1)'(NCH);
         end
         cand_idx = cand_sum[CHW-1:0];
         if (!grant_valid && !fifo_empty[cand_idx]) begin
            grant_valid = 1'b1;
            grant_ch    = cand_idx;
         end
      end
   end

   // Head of the granted FIFO, with the address zero-extended to bus width
   always_comb begin
      grant_cmd = fifo_dout[grant_ch];
      addr_ext  = '0;
      addr_ext[AW-1:0] = grant_cmd[ADDR_POS +: AW];
   end

   // Pop is combinational with the grant so the head is consumed on that edge
   always_comb begin
      pop = '0;
      if (do_grant) begin
         pop[grant_ch] = 1'b1;
      end
   end

   // Sequencer next state; one counter times ALE, AWAIT and WAIT_ACK and
   // restarts on every state change. ack is tested before the timeout so an
   // ack on the final cycle still completes normally.
   always_comb begin
      state_n    = state;
      cnt_n      = cnt + 1'b1;
      do_grant   = 1'b0;
      do_ack     = 1'b0;
      do_timeout = 1'b0;
      case (state)
         ST_IDLE: begin
            cnt_n = '0;
            if (grant_valid) begin
               do_grant = 1'b1;
               state_n  = ST_ALE;
            end
         end
         ST_ALE: begin
            if (cnt == ALE_LAST) begin
               state_n = (ADDR_WAIT == 0) ? ST_ASSERT : ST_AWAIT;
            end
         end
         ST_AWAIT: begin
            if (cnt == AWAIT_LAST) begin
               state_n = ST_ASSERT;
            end
         end
         ST_ASSERT: begin
            state_n = ST_WAIT_ACK;
         end
         ST_WAIT_ACK: begin
            if (!bus.ack_n) begin
               do_ack  = 1'b1;
               state_n = ST_RELEASE;
            end else if (cnt == TO_LAST) begin
               do_timeout = 1'b1;
               state_n    = ST_RELEASE;
            end
         end
         ST_RELEASE: begin
            state_n = ST_IDLE;
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase
      if (state_n != state) begin
         cnt_n = '0;
      end
   end

   // State and phase counter registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   // Bus pins are registered and change on the edge that leaves the state
   // that owns them, so ale rises one edge after the grant and cs_n falls on
   // the edge that leaves ASSERT; both release together on the response edge
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.ale   <= 1'b0;
         bus.cs_n  <= 1'b1;
         bus.rd_wr <= 1'b1;
         bus.data  <= '0;
         cur_rd    <= 1'b0;
         cur_ch    <= '0;
         cur_wdata <= '0;
         rr_ptr    <= '0;
      end else begin
         bus.ale  <= (state == ST_ALE);
         bus.cs_n <= !((state == ST_ASSERT) ||
                       ((state == ST_WAIT_ACK) && !do_ack && !do_timeout));
         if (do_grant) begin
            bus.rd_wr <= grant_cmd[RD_POS];
            bus.data  <= addr_ext;
            cur_rd    <= grant_cmd[RD_POS];
            cur_ch    <= grant_ch;
            cur_wdata <= grant_cmd[DATA_POS +: DW];
            rr_ptr    <= (grant_ch == CHW'(NCH - 1)) ? '0 : grant_ch + 1'b1;
         end else if (state == ST_ASSERT) begin
            bus.data  <= cur_wdata;
         end else if (do_ack || do_timeout) begin
            bus.rd_wr <= 1'b1;
         end
      end
   end

   // Response fields hold their last value between pulses
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rsp_valid   <= 1'b0;
         rsp_ch      <= '0;
         rsp_rd      <= 1'b0;
         rsp_timeout <= 1'b0;
         rsp_data    <= '0;
         timeout_cnt <= '0;
      end else begin
         rsp_valid <= do_ack || do_timeout;
         if (do_ack || do_timeout) begin
            rsp_ch      <= cur_ch;
            rsp_rd      <= cur_rd;
            rsp_timeout <= do_timeout;
            rsp_data    <= (do_ack && cur_rd) ? bus.rdata : '0;
         end
         if (do_timeout && (timeout_cnt != 16'hFFFF)) begin
            timeout_cnt <= timeout_cnt + 16'd1;
         end
      end
   end

   // Overflow flags stick until reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cmd_ovf <= '0;
      end else begin
         cmd_ovf <= cmd_ovf | (cmd_wr & fifo_full);
      end
   end

endmodule

// File: tb/tb_lbus_cmd_master.sv
// ----------------------------------------------------------------------------
// tb_lbus_cmd_master
// Self-checking bench for lbus_cmd_master (NCH=4, AW=DW=32, TIMEOUT=8).
// A target model acknowledges a programmable number of cycles after cs_n
// falls; a monitor logs the channel of every response pulse.
// ----------------------------------------------------------------------------
module tb_lbus_cmd_master;

   localparam int NCH = 4;
   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int CW  = 1 + AW + DW;

   typedef struct {
      int            ch;
      logic          rd;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      int            ack_dly;
      logic [DW-1:0] rdata;
      logic          exp_to;
      logic [DW-1:0] exp_data;
      logic [15:0]   exp_tocnt;
   } vec_t;

   logic             clk = 1'b0;
   logic             reset;
   logic [NCH*CW-1:0] cmd;
   logic [NCH-1:0]   cmd_wr;
   logic [NCH-1:0]   cmd_full;
   logic [NCH-1:0]   cmd_ovf;
   logic             rsp_valid;
   logic [1:0]       rsp_ch;
   logic             rsp_rd;
   logic             rsp_timeout;
   logic [DW-1:0]    rsp_data;
   logic             busy;
   logic [15:0]      timeout_cnt;

   lbus_cmd_master_if #(.DW(DW)) bus ();

   lbus_cmd_master #(
      .NCH        (NCH),
      .AW         (AW),
      .DW         (DW),
      .FIFO_DEPTH (16),
      .ALE_HOLD   (1),
      .ADDR_WAIT  (2),
      .TIMEOUT    (8)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .cmd         (cmd),
      .cmd_wr      (cmd_wr),
      .cmd_full    (cmd_full),
      .cmd_ovf     (cmd_ovf),
      .rsp_valid   (rsp_valid),
      .rsp_ch      (rsp_ch),
      .rsp_rd      (rsp_rd),
      .rsp_timeout (rsp_timeout),
      .rsp_data    (rsp_data),
      .bus         (bus),
      .busy        (busy),
      .timeout_cnt (timeout_cnt)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int ack_delay = 99;
   int low_cnt   = 0;
   int ch_log[$];
   int rsp_total = 0;

   // Target: ack_n low for one cycle, ack_delay cycles after cs_n fell
   always @(negedge clk) begin
      if (bus.cs_n == 1'b0) low_cnt++;
      else low_cnt = 0;
      bus.ack_n = (bus.cs_n == 1'b0 && low_cnt == ack_delay) ? 1'b0 : 1'b1;
   end

   // Response logger
   always @(negedge clk) begin
      if (rsp_valid === 1'b1) begin
         ch_log.push_back(int'(rsp_ch));
         rsp_total++;
      end
   end

   initial begin
      #300000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [NCH-1:0] mask, input logic rd,
                                input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
      for (int c = 0; c < NCH; c++) begin
         if (mask[c]) cmd[c*CW +: CW] = {rd, addr, wdata};
      end
      cmd_wr = mask;
      tick();
      cmd_wr = '0;
   endtask

   task automatic waitRspPulse(input string name, input int budget, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         tick();
         if (rsp_valid === 1'b1) seen = 1'b1;
      end
      if (!seen) checkOutput({name, "_rsp_timeout_bound"}, 64'd0, 64'd1);
   endtask

   task automatic waitLog(input string name, input int n, input int budget);
      for (int i = 0; i < budget && ch_log.size() < n; i++) tick();
      tick();
      checkOutput({name, "_count"}, 64'(ch_log.size()), 64'(n));
   endtask

   vec_t vecs[6];

   initial begin
      bit seen;
      int ch0_cnt;
      int busy_seen;
      int snap;

      vecs[0] = '{0, 1'b0, 32'h10, 32'hA5A5A5A5, 3,  32'h0,        1'b0, 32'h0,        16'd0};
      vecs[1] = '{2, 1'b1, 32'h20, 32'h0,        2,  32'h12345678, 1'b0, 32'h12345678, 16'd0};
      vecs[2] = '{1, 1'b1, 32'h40, 32'h0,        99, 32'hDEADBEEF, 1'b1, 32'h0,        16'd1};
      vecs[3] = '{1, 1'b1, 32'h44, 32'h0,        8,  32'hCAFEF00D, 1'b0, 32'hCAFEF00D, 16'd1};
      vecs[4] = '{0, 1'b0, 32'h50, 32'h11112222, 9,  32'h0,        1'b1, 32'h0,        16'd2};
      vecs[5] = '{3, 1'b1, 32'h60, 32'h0,        1,  32'h0000FFFF, 1'b0, 32'h0000FFFF, 16'd2};

      reset     = 1'b1;
      cmd       = '0;
      cmd_wr    = '0;
      bus.rdata = '0;
      tick();
      tick();
      checkOutput("rst_ale", bus.ale, 0);
      checkOutput("rst_cs_n", bus.cs_n, 1);
      checkOutput("rst_rd_wr", bus.rd_wr, 1);
      checkOutput("rst_data", bus.data, 0);
      checkOutput("rst_rsp", {rsp_valid, rsp_ch, rsp_rd, rsp_timeout, rsp_data}, 0);
      checkOutput("rst_ovf_full", {cmd_ovf, cmd_full}, 0);
      checkOutput("rst_tocnt", timeout_cnt, 0);
      checkOutput("rst_busy", busy, 0);
      reset = 1'b0;
      tick();

      // Single write on ch0: cycle-accurate bus sequence
      ack_delay = 3;
      applyStimulus(4'b0001, 1'b0, 32'h10, 32'hA5A5A5A5);
      checkOutput("wr_k_busy", busy, 0);
      tick();
      checkOutput("wr_k1_data", bus.data, 32'h10);
      checkOutput("wr_k1_rd_wr", bus.rd_wr, 0);
      checkOutput("wr_k1_ale", bus.ale, 0);
      checkOutput("wr_k1_busy", busy, 1);
      tick();
      checkOutput("wr_k2_ale", bus.ale, 1);
      checkOutput("wr_k2_cs_n", bus.cs_n, 1);
      tick();
      checkOutput("wr_k3_ale", bus.ale, 0);
      tick();
      checkOutput("wr_k4_cs_n", bus.cs_n, 1);
      tick();
      checkOutput("wr_k5_cs_n", bus.cs_n, 0);
      checkOutput("wr_k5_data", bus.data, 32'hA5A5A5A5);
      tick();
      tick();
      checkOutput("wr_k7_cs_n", bus.cs_n, 0);
      checkOutput("wr_k7_rsp_valid", rsp_valid, 0);
      tick();
      checkOutput("wr_k8_rsp_valid", rsp_valid, 1);
      checkOutput("wr_k8_rsp", {rsp_ch, rsp_rd, rsp_timeout, rsp_data}, 0);
      checkOutput("wr_k8_cs_n", bus.cs_n, 1);
      checkOutput("wr_k8_rd_wr", bus.rd_wr, 1);
      tick();
      checkOutput("wr_k9_rsp_valid", rsp_valid, 0);
      checkOutput("wr_k9_busy", busy, 0);

      // Table-driven single transactions
      for (int i = 0; i < 6; i++) begin
         ack_delay = vecs[i].ack_dly;
         bus.rdata = vecs[i].rdata;
         applyStimulus(4'(1 << vecs[i].ch), vecs[i].rd, vecs[i].addr, vecs[i].wdata);
         waitRspPulse($sformatf("vec%0d", i), 60, seen);
         if (seen) begin
            checkOutput($sformatf("vec%0d_ch", i), rsp_ch, 64'(vecs[i].ch));
            checkOutput($sformatf("vec%0d_rd", i), rsp_rd, vecs[i].rd);
            checkOutput($sformatf("vec%0d_to", i), rsp_timeout, vecs[i].exp_to);
            checkOutput($sformatf("vec%0d_data", i), rsp_data, vecs[i].exp_data);
            checkOutput($sformatf("vec%0d_cs_n", i), bus.cs_n, 1);
            checkOutput($sformatf("vec%0d_tocnt", i), timeout_cnt, vecs[i].exp_tocnt);
         end
         tick();
         checkOutput($sformatf("vec%0d_idle", i), busy, 0);
      end

      // Round robin: all four at once, then pointer-dependent pairs
      ack_delay = 1;
      ch_log.delete();
      applyStimulus(4'b1111, 1'b1, 32'h100, 32'h0);
      waitLog("rr_all", 4, 200);
      if (ch_log.size() >= 4) begin
         for (int i = 0; i < 4; i++) checkOutput($sformatf("rr_all_%0d", i), 64'(ch_log[i]), 64'(i));
      end
      ch_log.delete();
      applyStimulus(4'b0011, 1'b1, 32'h104, 32'h0);
      waitLog("rr_01", 2, 100);
      if (ch_log.size() >= 2) begin
         checkOutput("rr_01_first", 64'(ch_log[0]), 0);
         checkOutput("rr_01_second", 64'(ch_log[1]), 1);
      end
      ch_log.delete();
      applyStimulus(4'b1010, 1'b1, 32'h108, 32'h0);
      waitLog("rr_13", 2, 100);
      if (ch_log.size() >= 2) begin
         checkOutput("rr_13_first", 64'(ch_log[0]), 3);
         checkOutput("rr_13_second", 64'(ch_log[1]), 1);
      end

      // Overflow: ch2/ch3 hold the bus while ch0 receives 17 pushes
      ack_delay = 99;
      ch_log.delete();
      applyStimulus(4'b1110, 1'b0, 32'h200, 32'h0);
      for (int i = 1; i <= 17; i++) begin
         applyStimulus(4'b0001, 1'b0, 32'h300 + 32'(i), 32'(i));
         if (i == 15) checkOutput("ovf_full_at15", cmd_full[0], 0);
         if (i == 16) begin
            checkOutput("ovf_full_at16", cmd_full[0], 1);
            checkOutput("ovf_flag_at16", cmd_ovf, 0);
         end
      end
      checkOutput("ovf_flag_at17", cmd_ovf, 4'b0001);
      checkOutput("ovf_full_at17", cmd_full[0], 1);
      waitLog("ovf_rsp", 19, 600);
      ch0_cnt = 0;
      foreach (ch_log[j]) if (ch_log[j] == 0) ch0_cnt++;
      checkOutput("ovf_ch0_rsp", 64'(ch0_cnt), 16);
      checkOutput("ovf_tocnt", timeout_cnt, 21);
      checkOutput("ovf_full_drained", cmd_full, 0);

      // Reset in the middle of WAIT_ACK with another command still queued
      applyStimulus(4'b0110, 1'b1, 32'h400, 32'h0);
      for (int i = 0; i < 6; i++) tick();
      checkOutput("mid_cs_n_low", bus.cs_n, 0);
      snap = rsp_total;
      #2;
      reset = 1'b1;
      #1;
      checkOutput("mid_cs_n_async", bus.cs_n, 1);
      checkOutput("mid_busy_async", busy, 0);
      checkOutput("mid_rd_wr_async", bus.rd_wr, 1);
      checkOutput("mid_ovf_async", cmd_ovf, 0);
      checkOutput("mid_tocnt_async", timeout_cnt, 0);
      tick();
      tick();
      reset = 1'b0;
      busy_seen = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (busy !== 1'b0) busy_seen++;
      end
      checkOutput("mid_fifo_empty", 64'(busy_seen), 0);
      checkOutput("mid_no_rsp", 64'(rsp_total), 64'(snap));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
